// File: rtl/edge_img_pkg.sv
// Shared BMP definitions for the edge-image loader and writer: header field
// layout, header word generator and the writer state encoding.
package edge_img_pkg;

    localparam logic [15:0] BMP_MAGIC     = 16'h424D;
    localparam int unsigned BMP_HDR_BYTES = 54;
    localparam int unsigned BMP_DIB_BYTES = 40;
    localparam int unsigned BMP_PLANES    = 1;
    localparam int unsigned BMP_BPP       = 8;

    localparam int unsigned OFF_FILE_SIZE = 2;
    localparam int unsigned OFF_DATA_OFF  = 10;
    localparam int unsigned OFF_DIB_SIZE  = 14;
    localparam int unsigned OFF_WIDTH     = 18;
    localparam int unsigned OFF_HEIGHT    = 22;
    localparam int unsigned OFF_PLANES    = 26;
    localparam int unsigned OFF_BPP       = 28;
    localparam int unsigned OFF_IMG_SIZE  = 34;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PIXELS,
        ST_PAD,
        ST_DONE
    } wr_state_t;

    function automatic logic in_field(input logic [31:0] n, input int unsigned off,
                                      input int unsigned len);
        return (n >= off) && (n < off + len);
    endfunction

    // Byte n of the header; multi-byte fields are little-endian, unlisted bytes are zero.
    function automatic logic [7:0] bmp_header_byte(input logic [31:0] n, input logic [31:0] width,
                                                   input logic [31:0] depth, input logic [31:0] pad);
        logic [31:0] field;
        logic [31:0] base;
        logic [31:0] sel;
        logic [31:0] shifted;
        logic [31:0] img_bytes;
        img_bytes = depth * (width + pad);
        field     = 32'd0;
        base      = 32'd0;
        if (n < 32'd2) begin
            field = {16'd0, BMP_MAGIC[7:0], BMP_MAGIC[15:8]};
        end else if (in_field(n, OFF_FILE_SIZE, 4)) begin
            field = BMP_HDR_BYTES + img_bytes;
            base  = OFF_FILE_SIZE;
        end else if (in_field(n, OFF_DATA_OFF, 4)) begin
            field = BMP_HDR_BYTES;
            base  = OFF_DATA_OFF;
        end else if (in_field(n, OFF_DIB_SIZE, 4)) begin
            field = BMP_DIB_BYTES;
            base  = OFF_DIB_SIZE;
        end else if (in_field(n, OFF_WIDTH, 4)) begin
            field = width;
            base  = OFF_WIDTH;
        end else if (in_field(n, OFF_HEIGHT, 4)) begin
            field = depth;
            base  = OFF_HEIGHT;
        end else if (in_field(n, OFF_PLANES, 2)) begin
            field = BMP_PLANES;
            base  = OFF_PLANES;
        end else if (in_field(n, OFF_BPP, 2)) begin
            field = BMP_BPP;
            base  = OFF_BPP;
        end else if (in_field(n, OFF_IMG_SIZE, 4)) begin
            field = img_bytes;
            base  = OFF_IMG_SIZE;
        end
        sel     = n - base;
        shifted = field >> {sel[1:0], 3'b000};
        return shifted[7:0];
    endfunction

    function automatic logic [15:0] bmp_header_word(input logic [31:0] idx, input logic [31:0] width,
                                                    input logic [31:0] depth, input logic [31:0] pad);
        return {bmp_header_byte({idx[30:0], 1'b0}, width, depth, pad),
                bmp_header_byte({idx[30:0], 1'b1}, width, depth, pad)};
    endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Header word lookup: index -> 16-bit BMP header word for the configured frame geometry.
module bmp_header_rom
    import edge_img_pkg::*;
#(
    parameter int unsigned WIDTH         = 128,
    parameter int unsigned DEPTH         = 128,
    parameter int unsigned ROW_PAD_BYTES = 8,
    parameter int unsigned IDX_W         = 5
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [15:0]      word_o
);

    assign word_o = bmp_header_word(32'(idx_i), WIDTH, DEPTH, ROW_PAD_BYTES);

endmodule

// File: rtl/bmp_stream_writer.sv
// Serialises one frame as 16-bit BMP words: header, then rows of paired pixels plus zero padding.
// Optional running word checksum output when BMP_WRITER_CHECKSUM_EN is defined.
module bmp_stream_writer
    import edge_img_pkg::*;
#(
    parameter int unsigned WIDTH         = 128,
    parameter int unsigned DEPTH         = 128,
    parameter int unsigned HDR_BYTES     = 54,
    parameter int unsigned ROW_PAD_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [15:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy,
`ifdef BMP_WRITER_CHECKSUM_EN
    output logic [15:0] checksum,
`endif
    output logic        done
);

    localparam int unsigned HDR_WORDS = HDR_BYTES / 2;
    // With odd WIDTH the first pad word carries the row's last pixel in its high byte.
    localparam int unsigned PAD_WORDS = (ROW_PAD_BYTES + WIDTH % 2) / 2;
    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned HDR_W = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
    localparam int unsigned PAD_W = (PAD_WORDS > 0) ? $clog2(PAD_WORDS + 1) : 1;

    wr_state_t        state_q, state_d;
    logic [15:0]      word_q, word_d;
    logic             word_valid_q, word_valid_d;
    logic [7:0]       hi_q, hi_d;
    logic             hi_full_q, hi_full_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [HDR_W-1:0] hdr_q, hdr_d;
    logic [PAD_W-1:0] pad_q, pad_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef BMP_WRITER_CHECKSUM_EN
    logic [15:0]      sum_q, sum_d;
`endif

    logic [HDR_W-1:0] rom_idx;
    logic [15:0]      rom_word;
    logic             word_fire;
    logic             slot_free;
    logic             pix_fire;
    logic             last_col;

    // While a header word is on the bus the ROM looks one entry ahead.
    assign rom_idx = word_valid_q ? hdr_q + 1'b1 : hdr_q;

    bmp_header_rom #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .ROW_PAD_BYTES (ROW_PAD_BYTES),
        .IDX_W         (HDR_W)
    ) u_header_rom (
        .idx_i  (rom_idx),
        .word_o (rom_word)
    );

    assign word_fire = word_valid_q && word_ready;
    assign slot_free = !word_valid_q || word_ready;
    assign pix_ready = (state_q == ST_PIXELS) && (!hi_full_q || slot_free);
    assign pix_fire  = pix_valid && pix_ready;
    assign last_col  = (col_q == COL_W'(WIDTH - 1));

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        hi_d         = hi_q;
        hi_full_d    = hi_full_q;
        col_d        = col_q;
        row_d        = row_q;
        hdr_d        = hdr_q;
        pad_d        = pad_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef BMP_WRITER_CHECKSUM_EN
        sum_d        = word_fire ? sum_q + word_q : sum_q;
`endif
        if (word_fire) begin
            word_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_HEADER;
                    busy_d    = 1'b1;
                    hdr_d     = '0;
                    col_d     = '0;
                    row_d     = '0;
                    pad_d     = '0;
                    hi_full_d = 1'b0;
`ifdef BMP_WRITER_CHECKSUM_EN
                    sum_d     = 16'h0000;
`endif
                end
            end
            ST_HEADER: begin
                if (!word_valid_q) begin
                    word_d       = rom_word;
                    word_valid_d = 1'b1;
                end else if (word_fire) begin
                    if (hdr_q == HDR_W'(HDR_WORDS - 1)) begin
                        hdr_d   = '0;
                        state_d = ST_PIXELS;
                    end else begin
                        hdr_d        = hdr_q + 1'b1;
                        word_d       = rom_word;
                        word_valid_d = 1'b1;
                    end
                end
            end
            ST_PIXELS: begin
                if (pix_fire) begin
                    col_d = last_col ? '0 : col_q + 1'b1;
                    if (hi_full_q) begin
                        word_d       = {hi_q, pix_data};
                        word_valid_d = 1'b1;
                        hi_full_d    = 1'b0;
                    end else begin
                        hi_d      = pix_data;
                        hi_full_d = 1'b1;
                    end
                    if (last_col) begin
                        state_d = ST_PAD;
                        pad_d   = '0;
                    end
                end
            end
            ST_PAD: begin
                if (pad_q != PAD_W'(PAD_WORDS)) begin
                    if (slot_free) begin
                        word_d       = {hi_full_q ? hi_q : 8'h00, 8'h00};
                        word_valid_d = 1'b1;
                        hi_full_d    = 1'b0;
                        pad_d        = pad_q + 1'b1;
                    end
                end else if (row_q != ROW_W'(DEPTH - 1)) begin
                    row_d   = row_q + 1'b1;
                    state_d = ST_PIXELS;
                end else if (slot_free) begin
                    // Last row: leave only once the final word has been taken.
                    row_d   = '0;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_q       <= 16'h0000;
            word_valid_q <= 1'b0;
            hi_q         <= 8'h00;
            hi_full_q    <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            hdr_q        <= '0;
            pad_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef BMP_WRITER_CHECKSUM_EN
            sum_q        <= 16'h0000;
`endif
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            hi_q         <= hi_d;
            hi_full_q    <= hi_full_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hdr_q        <= hdr_d;
            pad_q        <= pad_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef BMP_WRITER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign word_data  = word_q;
    assign word_valid = word_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef BMP_WRITER_CHECKSUM_EN
    assign checksum   = sum_q;
`endif

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Randomised bench for bmp_stream_writer: three geometries (small, odd width, default)
// checked against a byte-level BMP file model. Checksum checks with BMP_WRITER_CHECKSUM_EN.
module tb_bmp_stream_writer;

    function automatic int cfg_w(input int k);
        case (k)
            0:       return 4;
            1:       return 5;
            default: return 128;
        endcase
    endfunction

    function automatic int cfg_d(input int k);
        case (k)
            0:       return 2;
            1:       return 3;
            default: return 128;
        endcase
    endfunction

    function automatic int cfg_p(input int k);
        case (k)
            0:       return 2;
            1:       return 3;
            default: return 8;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start_s = 1'b0;
    logic        pix_valid_s = 1'b0;
    logic        word_ready_s = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    int          sel = 0;

    logic        pix_ready_v  [3];
    logic        word_valid_v [3];
    logic        busy_v       [3];
    logic        done_v       [3];
    logic [15:0] word_data_v  [3];
`ifdef BMP_WRITER_CHECKSUM_EN
    logic [15:0] sum_v        [3];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            bmp_stream_writer #(
                .WIDTH         (cfg_w(gi)),
                .DEPTH         (cfg_d(gi)),
                .HDR_BYTES     (54),
                .ROW_PAD_BYTES (cfg_p(gi))
            ) dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .start      (start_s && (sel == gi)),
                .pix_data   (pix_data),
                .pix_valid  (pix_valid_s && (sel == gi)),
                .pix_ready  (pix_ready_v[gi]),
                .word_data  (word_data_v[gi]),
                .word_valid (word_valid_v[gi]),
                .word_ready (word_ready_s),
                .busy       (busy_v[gi]),
`ifdef BMP_WRITER_CHECKSUM_EN
                .checksum   (sum_v[gi]),
`endif
                .done       (done_v[gi])
            );
        end
    endgenerate

    logic        pix_ready, word_valid, busy, done;
    logic [15:0] word_data;
    always_comb begin
        pix_ready  = pix_ready_v[sel];
        word_valid = word_valid_v[sel];
        busy       = busy_v[sel];
        done       = done_v[sel];
        word_data  = word_data_v[sel];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  pix_q   [$];
    logic [7:0]  bytes_q [$];
    logic [15:0] exp_q   [$];
    logic [15:0] obs_q   [$];

    function automatic void push_le(input int unsigned v, input int n);
        for (int i = 0; i < n; i++) bytes_q.push_back(8'(v >> (8 * i)));
    endfunction

    // The whole file as a byte stream, then paired into words.
    function automatic void build_expected(input int w, input int d, input int p);
        bytes_q.delete();
        bytes_q.push_back(8'h42);
        bytes_q.push_back(8'h4D);
        push_le(54 + d * (w + p), 4);
        push_le(0, 4);
        push_le(54, 4);
        push_le(40, 4);
        push_le(w, 4);
        push_le(d, 4);
        push_le(1, 2);
        push_le(8, 2);
        push_le(0, 4);
        push_le(d * (w + p), 4);
        push_le(0, 16);
        for (int r = 0; r < d; r++) begin
            for (int c = 0; c < w; c++) bytes_q.push_back(pix_q[r * w + c]);
            for (int c = 0; c < p; c++) bytes_q.push_back(8'h00);
        end
        exp_q.delete();
        for (int i = 0; i + 1 < bytes_q.size(); i += 2) exp_q.push_back({bytes_q[i], bytes_q[i + 1]});
    endfunction

    task automatic run_frame(input int k, input string name, input int gap_pct, input int stall_pct,
                             input bit spam, input int abort_at, input bit ramp);
        int w, d, p, npix, pix_idx, word_idx, dones, cyc, post, limit;
        bit held;
        logic [15:0] held_word;
        logic [15:0] sum;
        w = cfg_w(k);
        d = cfg_d(k);
        p = cfg_p(k);
        npix = w * d;
        pix_q.delete();
        obs_q.delete();
        for (int i = 0; i < npix; i++) pix_q.push_back(ramp ? 8'(i + 1) : 8'($urandom));
        build_expected(w, d, p);
        limit = 200 + 20 * exp_q.size();

        sel = k;
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check({name, ":busy_after_start"}, 32'(busy), 32'd1);

        pix_idx = 0; word_idx = 0; dones = 0; cyc = 0; post = 0; held = 1'b0; held_word = 16'h0;
        while (post < 4) begin
            word_ready_s = ($urandom_range(99) >= stall_pct);
            pix_valid_s  = (pix_idx < npix) && ($urandom_range(99) >= gap_pct);
            pix_data     = pix_valid_s ? pix_q[pix_idx] : 8'h00;
            start_s      = spam && (dones == 0) && ($urandom_range(99) < 5);
            #1;
            if (held) check({name, ":hold"}, {15'd0, word_valid, word_data}, {15'd0, 1'b1, held_word});
            held      = word_valid && !word_ready_s;
            held_word = word_data;
            if (word_valid && word_ready_s) begin
                obs_q.push_back(word_data);
                if (word_idx < exp_q.size())
                    check($sformatf("%s:word%0d", name, word_idx), 32'(word_data), 32'(exp_q[word_idx]));
                else
                    check({name, ":extra_word"}, word_idx, exp_q.size());
                word_idx++;
            end
            if (pix_valid_s && pix_ready) pix_idx++;
            if (done) dones++;
            if (abort_at >= 0 && pix_idx == abort_at) begin
                rst_n = 1'b0;
                pix_valid_s = 1'b0;
                start_s = 1'b0;
                @(negedge clk);
                #1;
                check({name, ":rst_word_valid"}, 32'(word_valid), 32'd0);
                check({name, ":rst_pix_ready"}, 32'(pix_ready), 32'd0);
                check({name, ":rst_busy"}, 32'(busy), 32'd0);
                check({name, ":rst_word_data"}, 32'(word_data), 32'd0);
                rst_n = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check({name, ":quiet_after_rst"}, {30'd0, word_valid, busy}, 32'd0);
                end
                $display("frame %s: aborted by reset after %0d pixels, %0d words", name, pix_idx, word_idx);
                return;
            end
            @(negedge clk);
            cyc++;
            if (dones > 0) post++;
            if (cyc > limit) begin
                check({name, ":timeout"}, cyc, limit);
                break;
            end
        end
        start_s = 1'b0;
        pix_valid_s = 1'b0;
        word_ready_s = 1'b1;
        check({name, ":word_count"}, word_idx, exp_q.size());
        check({name, ":pixel_count"}, pix_idx, npix);
        check({name, ":done_pulses"}, dones, 1);
        check({name, ":idle_after"}, {30'd0, busy, word_valid}, 32'd0);
`ifdef BMP_WRITER_CHECKSUM_EN
        sum = 16'h0;
        foreach (exp_q[i]) sum += exp_q[i];
        check({name, ":checksum"}, 32'(sum_v[k]), 32'(sum));
`else
        sum = 16'h0;
`endif
        $display("frame %s: %0d words, %0d pixels, %0d cycles, sum %04h", name, word_idx, pix_idx, cyc, sum);
    endtask

    logic [15:0] t1_tail [6];

    initial begin
        t1_tail = '{16'h0102, 16'h0304, 16'h0000, 16'h0506, 16'h0708, 16'h0000};
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset%0d:busy", k), 32'(busy_v[k]), 32'd0);
            check($sformatf("reset%0d:word_valid", k), 32'(word_valid_v[k]), 32'd0);
            check($sformatf("reset%0d:pix_ready", k), 32'(pix_ready_v[k]), 32'd0);
            check($sformatf("reset%0d:done", k), 32'(done_v[k]), 32'd0);
            check($sformatf("reset%0d:word_data", k), 32'(word_data_v[k]), 32'd0);
`ifdef BMP_WRITER_CHECKSUM_EN
            check($sformatf("reset%0d:checksum", k), 32'(sum_v[k]), 32'd0);
`endif
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, "t1", 0, 0, 1'b0, -1, 1'b1);
        check("t1:first_word", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hDEAD, 32'h424D);
        check("t1:file_size_word", (obs_q.size() > 1) ? 32'(obs_q[1]) : 32'hDEAD, 32'h4200);
        for (int i = 0; i < 6; i++)
            check($sformatf("t1:tail%0d", i), (27 + i < obs_q.size()) ? 32'(obs_q[27 + i]) : 32'hDEAD,
                  32'(t1_tail[i]));
        run_frame(0, "t1_again", 0, 0, 1'b0, -1, 1'b1);
        run_frame(0, "gaps", 50, 0, 1'b0, -1, 1'b1);
        run_frame(1, "odd", 20, 30, 1'b0, -1, 1'b0);
        run_frame(1, "start_spam", 10, 20, 1'b1, -1, 1'b0);
        run_frame(0, "start_spam_small", 30, 40, 1'b1, -1, 1'b0);
        run_frame(1, "abort", 10, 20, 1'b0, 7, 1'b0);
        run_frame(1, "after_abort", 10, 20, 1'b0, -1, 1'b0);
        run_frame(2, "default", 10, 30, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
